demux1to4_reg: RTL

DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

---
 rtl/alu16_pkg.sv | 9 +
 rtl/demux1to4_reg_if.sv | 25 ++
 rtl/demux1to4_reg_route_slot.sv | 20 ++
 rtl/demux1to4_reg.sv | 39 +++
 4 files changed

// File: rtl/alu16_pkg.sv
// alu16_pkg: shared routing constants and the select decoder.
package alu16_pkg;
  localparam int sel_w  = 2;
  localparam int dest_n = 4;
  localparam int cnt_w  = 16;
  function automatic logic [dest_n-1:0] onehot(input logic [sel_w-1:0] s);
    return dest_n'(1) << s;
  endfunction
endpackage

// File: rtl/demux1to4_reg_if.sv
// demux1to4_reg_if: input channel, four output slots and transfer counter.
interface demux1to4_reg_if
  import alu16_pkg::*;
#(parameter int w = 32);
  logic [w-1:0]      in_data;
  logic [sel_w-1:0]  in_sel;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [w-1:0]      out0;
  logic [w-1:0]      out1;
  logic [w-1:0]      out2;
  logic [w-1:0]      out3;
  logic [dest_n-1:0] out_valid;
  logic [dest_n-1:0] out_ready;
  logic [cnt_w-1:0]  xfer_cnt;
  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid, xfer_cnt
  );
  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid, xfer_cnt
  );
endinterface

// File: rtl/demux1to4_reg_route_slot.sv
// route_slot: one-entry holding register for a single destination.
module route_slot #(parameter int w = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [w-1:0] d,
  output logic [w-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) q <= d;
      valid <= ~clear & (load | (valid & ~drain));
    end
endmodule

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: routes each accepted word into one of four registered output slots.
module demux1to4_reg
  import alu16_pkg::*;
#(parameter int w = 32) (
  input logic            clk,
  input logic            rst_n,
  demux1to4_reg_if.slave bus
);
  logic [w-1:0]      q [dest_n];
  logic [dest_n-1:0] valid;
  logic [dest_n-1:0] load;
  logic              accept;
  logic [cnt_w-1:0]  cnt;
  // a slot that drains this cycle can take a new word without a bubble
  assign bus.in_ready = rst_n & ~bus.flush & (~valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = accept ? onehot(bus.in_sel) : '0;
  for (genvar k = 0; k < dest_n; k++) begin : g_slot
    route_slot #(.w(w)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .drain (bus.out_ready[k]),
      .clear (bus.flush),
      .d     (bus.in_data),
      .q     (q[k]),
      .valid (valid[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (accept) cnt <= cnt + cnt_w'(1);
  assign bus.out0      = q[0];
  assign bus.out1      = q[1];
  assign bus.out2      = q[2];
  assign bus.out3      = q[3];
  assign bus.out_valid = valid;
  assign bus.xfer_cnt  = cnt;
endmodule
